mps_cpu_multicycle: RTL and testbench
=====================================

Name: mps_cpu_multicycle

Overview:
Multi-cycle MPS (MIPS-subset) core, the successor to the single-cycle CPU. It keeps one shared memory port for instruction fetch and for data, and uses a ready handshake so memory can insert wait states. It adds a reset-vector parameter, a bus timeout, fault reporting and a halt state. It sits between the instruction/data memory model and the testbench top.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset; must be word-aligned.
WAIT_TIMEOUT, 0, max wait cycles per memory access before a fault; 0 = unlimited.

Ports:
clock  in  1  system clock, rising edge
nreset  in  1  asynchronous active-low reset
mem_req  out  1  memory access request, held until accepted
mem_we  out  1  1 = write, 0 = read; valid while mem_req=1
mem_addr  out  32  byte address, word-aligned
mem_wdata  out  32  store data; valid while mem_req=1 and mem_we=1
mem_rdata  in  32  load/fetch data, sampled on the edge where mem_ready=1
mem_ready  in  1  access completes on a rising edge where mem_req=1 and mem_ready=1
halted  out  1  core stopped in the HALT state
fault  out  2  0 = none, 1 = illegal instruction, 2 = bus timeout, 3 = misaligned data address
pc  out  32  current PC, for debug

Behaviour:
- Clock and reset: one clock, `clock`; reset `nreset` is asynchronous and active-low.
- Reset values (asynchronous):
  - state=FETCH, pc=RESET_PC
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - halted=0, fault=0, IR/A/B/ALUOUT/MDR=0
  - all 32 registers = 0
- Reset mid-access drops mem_req immediately; the access is abandoned.
- ISA: R-type (op 0x00) with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A. Also j 0x02, beq 0x04, addi 0x08, lw 0x23, sw 0x2B.
- Arithmetic: 32-bit, wrap-around, no overflow trap. slt is a signed compare giving 1 or 0. The immediate is sign-extended.
- Register $0 always reads 0; writes to $0 are discarded.
- FSM (all transitions on a rising clock edge):
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On mem_ready: IR<=mem_rdata, pc<=pc+4, go to DECODE.
  - DECODE: A<=reg[rs], B<=reg[rt], ALUOUT<=pc+(sext(imm)<<2). Illegal opcode or funct -> HALT with fault=1.
  - EXEC:
    - R-type: ALUOUT<=A op B, go to WB.
    - addi: ALUOUT<=A+sext(imm), go to WB.
    - lw/sw: ALUOUT<=A+sext(imm). If the result's bits [1:0]!=0, go to HALT with fault=3 and perform no access; otherwise go to MEM.
    - beq: if A==B then pc<=ALUOUT. Go to FETCH.
    - j: pc<={pc[31:28],target,2'b00}. Go to FETCH.
  - MEM: mem_req=1, mem_addr=ALUOUT. For sw, mem_we=1 and mem_wdata=B. On mem_ready: lw sets MDR<=mem_rdata and goes to WB; sw goes to FETCH.
  - WB: R-type writes ALUOUT to reg[rd]. addi writes ALUOUT to reg[rt]. lw writes MDR to reg[rt]. Go to FETCH.
  - HALT: terminal until reset. halted=1, mem_req=0, fault held.
- CPI with zero-wait memory (mem_ready=1 in the same cycle as the request): beq/j 3, R-type/addi/sw 4, lw 5. Each wait cycle adds 1.
- Wait counter:
  - Cleared on entry to FETCH and to MEM; increments every cycle with mem_req=1 and mem_ready=0.
  - If WAIT_TIMEOUT>0 and the counter reaches WAIT_TIMEOUT with ready still low, the next edge goes to HALT with fault=2 and mem_req drops.
  - mem_ready arriving on that same edge wins: the access completes normally.
- mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and the access is not yet accepted.
- mem_ready while mem_req=0 is ignored.

Optional Feature:
MPS_PERF_COUNTERS_EN
- Defined: adds output ports cycle_count[31:0] and instret[31:0], both reset to 0.
  - cycle_count increments every cycle while not halted.
  - instret increments on the edge that completes an instruction: leaving WB, leaving MEM for sw, or leaving EXEC for beq/j.
  - Both counters wrap at 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Zero-wait memory, program `addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1` -> reg3=2, reg4=1; 16 cycles from reset release to 4th WB completion.
- `addi $1,$0,0x40; sw $1,4($1); lw $5,4($1)` -> write seen at addr 0x44 with data 0x40; reg5=0x40. With 2 wait cycles per access, the lw takes 9 cycles.
- `beq $0,$0,+2` at pc 0x10 -> next fetch at 0x1C. `j 0x100` -> next fetch at 0x400.
- `addi $0,$0,7; add $6,$0,$0` -> reg6=0 (the $0 write was discarded).
- Opcode 0x3F -> halted=1, fault=1, mem_req stays 0. With WAIT_TIMEOUT=4 and ready held low -> halted after 4 wait cycles, fault=2. `lw` to 0x41 -> fault=3 with no mem_req.
- Assert nreset low during a MEM wait -> mem_req=0 in the same cycle; after release the first fetch is at RESET_PC=0x100 with all registers 0. With MPS_PERF_COUNTERS_EN, instret=4 after the first program.

Source files
------------

// File: rtl/mps_cpu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : mps_cpu_multicycle
// Description : Multi-cycle MIPS-subset core with one shared, handshaked
//               memory port, bus timeout, fault reporting and halt state.
//               Optional perf counters when MPS_PERF_COUNTERS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module mps_cpu_multicycle #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned WAIT_TIMEOUT = 0
) (
    input  logic        clock,
    input  logic        nreset,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halted,
    output logic [1:0]  fault,
    output logic [31:0] pc
`ifdef MPS_PERF_COUNTERS_EN
    ,
    output logic [31:0] cycle_count,
    output logic [31:0] instret
`endif
);

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    localparam logic [1:0] c_FAULT_NONE    = 2'd0;
    localparam logic [1:0] c_FAULT_ILLEGAL = 2'd1;
    localparam logic [1:0] c_FAULT_TIMEOUT = 2'd2;
    localparam logic [1:0] c_FAULT_ALIGN   = 2'd3;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] alu_q;
    logic [31:0] mdr_q;
    logic [31:0] wait_q;
    logic        halted_q;
    logic [1:0]  fault_q;
    logic [31:0] rf_q [32];

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [5:0]  w_funct;
    logic [31:0] w_imm_sext;
    logic        w_legal;
    logic        w_req;
    logic        w_timeout;
    logic [31:0] alu_d;

    assign w_op       = ir_q[31:26];
    assign w_rs       = ir_q[25:21];
    assign w_rt       = ir_q[20:16];
    assign w_rd       = ir_q[15:11];
    assign w_funct    = ir_q[5:0];
    assign w_imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            c_OP_RTYPE: begin
                case (w_funct)
                    c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_SLT: w_legal = 1'b1;
                    default:                                         w_legal = 1'b0;
                endcase
            end
            c_OP_J, c_OP_BEQ, c_OP_ADDI, c_OP_LW, c_OP_SW: w_legal = 1'b1;
            default:                                        w_legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_d = a_q + w_imm_sext;
        if (w_op == c_OP_RTYPE) begin
            case (w_funct)
                c_FN_SUB: alu_d = a_q - b_q;
                c_FN_AND: alu_d = a_q & b_q;
                c_FN_OR:  alu_d = a_q | b_q;
                c_FN_SLT: alu_d = {31'b0, ($signed(a_q) < $signed(b_q))};
                default:  alu_d = a_q + b_q;
            endcase
        end
    end

    // Request is decoded from state so a zero-wait access completes in the
    // state's first cycle; gating with nreset drops it the instant reset hits.
    assign w_req     = nreset && ((state_q == S_FETCH) || (state_q == S_MEM));
    assign w_timeout = (WAIT_TIMEOUT != 0) && (wait_q == WAIT_TIMEOUT);

    assign mem_req   = w_req;
    assign mem_we    = w_req && (state_q == S_MEM) && (w_op == c_OP_SW);
    assign mem_addr  = !w_req ? 32'h0 : ((state_q == S_FETCH) ? pc_q : alu_q);
    assign mem_wdata = mem_we ? b_q : 32'h0;

    assign halted = halted_q;
    assign fault  = fault_q;
    assign pc     = pc_q;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            alu_q    <= '0;
            mdr_q    <= '0;
            wait_q   <= '0;
            halted_q <= 1'b0;
            fault_q  <= c_FAULT_NONE;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_q    <= mem_rdata;
                        pc_q    <= pc_q + 32'd4;
                        wait_q  <= '0;
                        state_q <= S_DECODE;
                    end else if (w_timeout) begin
                        halted_q <= 1'b1;
                        fault_q  <= c_FAULT_TIMEOUT;
                        state_q  <= S_HALT;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_DECODE: begin
                    wait_q <= '0;
                    a_q    <= rf_q[w_rs];
                    b_q    <= rf_q[w_rt];
                    alu_q  <= pc_q + {w_imm_sext[29:0], 2'b00};
                    if (w_legal) begin
                        state_q <= S_EXEC;
                    end else begin
                        halted_q <= 1'b1;
                        fault_q  <= c_FAULT_ILLEGAL;
                        state_q  <= S_HALT;
                    end
                end
                S_EXEC: begin
                    wait_q <= '0;
                    case (w_op)
                        c_OP_BEQ: begin
                            if (a_q == b_q) begin
                                pc_q <= alu_q;
                            end
                            state_q <= S_FETCH;
                        end
                        c_OP_J: begin
                            pc_q    <= {pc_q[31:28], ir_q[25:0], 2'b00};
                            state_q <= S_FETCH;
                        end
                        c_OP_LW, c_OP_SW: begin
                            alu_q <= alu_d;
                            if (alu_d[1:0] != 2'b00) begin
                                halted_q <= 1'b1;
                                fault_q  <= c_FAULT_ALIGN;
                                state_q  <= S_HALT;
                            end else begin
                                state_q <= S_MEM;
                            end
                        end
                        default: begin
                            alu_q   <= alu_d;
                            state_q <= S_WB;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        wait_q <= '0;
                        if (w_op == c_OP_LW) begin
                            mdr_q   <= mem_rdata;
                            state_q <= S_WB;
                        end else begin
                            state_q <= S_FETCH;
                        end
                    end else if (w_timeout) begin
                        halted_q <= 1'b1;
                        fault_q  <= c_FAULT_TIMEOUT;
                        state_q  <= S_HALT;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_WB: begin
                    wait_q <= '0;
                    case (w_op)
                        c_OP_RTYPE: if (w_rd != 5'd0) rf_q[w_rd] <= alu_q;
                        c_OP_ADDI:  if (w_rt != 5'd0) rf_q[w_rt] <= alu_q;
                        c_OP_LW:    if (w_rt != 5'd0) rf_q[w_rt] <= mdr_q;
                        default:    ;
                    endcase
                    state_q <= S_FETCH;
                end
                default: begin
                    halted_q <= 1'b1;
                    state_q  <= S_HALT;
                end
            endcase
        end
    end

`ifdef MPS_PERF_COUNTERS_EN
    logic        w_retire;
    logic [31:0] cycle_q;
    logic [31:0] instret_q;

    assign w_retire = (state_q == S_WB)
                   || ((state_q == S_MEM) && mem_ready && (w_op == c_OP_SW))
                   || ((state_q == S_EXEC) && ((w_op == c_OP_BEQ) || (w_op == c_OP_J)));

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (!halted_q) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (w_retire) begin
                instret_q <= instret_q + 32'd1;
            end
        end
    end

    assign cycle_count = cycle_q;
    assign instret     = instret_q;
`else
    // No performance counters in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_mps_cpu_multicycle.sv
`default_nettype none
// ============================================================================
// Module      : tb_mps_cpu_multicycle
// Description : Scoreboard bench: expected bus transactions are queued per
//               program; the memory model pops and compares on each accept.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mps_cpu_multicycle;

    localparam logic [31:0] c_ILL = 32'hFC00_0000;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        int          gap;
    } tx_t;

    logic        clock;
    logic        nreset;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        halted;
    logic [1:0]  fault;
    logic [31:0] pc;
`ifdef MPS_PERF_COUNTERS_EN
    logic [31:0] cycle_count;
    logic [31:0] instret;
`endif

    logic [31:0] mem [0:1023];
    tx_t         exp_q [$];
    int          n_tests;
    int          n_fail;
    int          waits;
    int          wcnt;
    int          cyc;
    int          last_acc;
    string       cur_test;

    mps_cpu_multicycle #(
        .RESET_PC     (32'h0000_0100),
        .WAIT_TIMEOUT (4)
    ) dut (
        .clock     (clock),
        .nreset    (nreset),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .halted    (halted),
        .fault     (fault),
        .pc        (pc)
`ifdef MPS_PERF_COUNTERS_EN
        ,
        .cycle_count (cycle_count),
        .instret     (instret)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] enc_j(input int target);
        return {6'h02, 26'(target)};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %h, expected %h", cur_test, name, got, exp);
        end
    endtask

    task automatic expect_tx(input logic we, input logic [31:0] addr, input logic [31:0] data, input int gap);
        tx_t t;
        t.we   = we;
        t.addr = addr;
        t.data = data;
        t.gap  = gap;
        exp_q.push_back(t);
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] word);
        mem[addr[11:2]] = word;
    endtask

    task automatic begin_test(input string name, input int w);
        @(posedge clock);
        #1 nreset = 1'b0;
        cur_test = name;
        waits    = w;
        exp_q.delete();
        for (int i = 0; i < 1024; i++) mem[i] = c_ILL;
        repeat (2) @(negedge clock);
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1 nreset = 1'b1;
    endtask

    task automatic run_to_halt(input logic [1:0] exp_fault);
        bit seen;
        seen = 1'b0;
        release_reset();
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clock);
            if (halted) seen = 1'b1;
        end
        chk("halt_reached", 32'(seen), 32'd1);
        repeat (3) @(negedge clock);
        chk("fault", 32'(fault), 32'(exp_fault));
        chk("req_idle_in_halt", 32'(mem_req), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Memory model and scoreboard: ready is decided on the falling edge, so a
    // transaction logged here is the one the core accepts on the next rising edge.
    always @(negedge clock) begin : mem_model
        tx_t e;
        int  gap;
        bit  ok;
        if (!nreset) begin
            mem_ready = 1'b0;
            wcnt      = 0;
            cyc       = 0;
            last_acc  = 0;
        end else begin
            cyc++;
            if (mem_req) begin
                if (wcnt >= waits) begin
                    mem_ready = 1'b1;
                    gap       = cyc - last_acc;
                    last_acc  = cyc;
                    wcnt      = 0;
                    if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
                    else        mem_rdata = mem[mem_addr[11:2]];
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s/unexpected_access: got we=%0b addr=%h, expected no access",
                                 cur_test, mem_we, mem_addr);
                    end else begin
                        e  = exp_q.pop_front();
                        ok = (mem_we == e.we) && (mem_addr == e.addr) && (gap == e.gap)
                             && (!e.we || (mem_wdata == e.data));
                        if (!ok) begin
                            n_fail++;
                            $display("FAIL %s/bus: got we=%0b addr=%h wdata=%h gap=%0d, expected we=%0b addr=%h wdata=%h gap=%0d",
                                     cur_test, mem_we, mem_addr, mem_wdata, gap, e.we, e.addr, e.data, e.gap);
                        end
                    end
                end else begin
                    mem_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ready = 1'b0;
                wcnt      = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        n_tests   = 0;
        n_fail    = 0;
        nreset    = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        waits     = 0;
        cur_test  = "reset";

        // Reset values
        repeat (2) @(negedge clock);
        chk("mem_req", 32'(mem_req), 32'd0);
        chk("mem_we", 32'(mem_we), 32'd0);
        chk("mem_addr", mem_addr, 32'h0);
        chk("mem_wdata", mem_wdata, 32'h0);
        chk("halted", 32'(halted), 32'd0);
        chk("fault", 32'(fault), 32'd0);
        chk("pc", pc, 32'h100);

        // ALU program, zero-wait memory, results stored to the bus
        begin_test("alu", 0);
        load(32'h100, enc_i(6'h08, 0, 1, 5));
        load(32'h104, enc_i(6'h08, 0, 2, -3));
        load(32'h108, enc_r(1, 2, 3, 6'h20));
        load(32'h10C, enc_r(2, 1, 4, 6'h2A));
        load(32'h110, enc_i(6'h2B, 0, 3, 32'h200));
        load(32'h114, enc_i(6'h2B, 0, 4, 32'h204));
        load(32'h118, enc_i(6'h08, 0, 0, 7));
        load(32'h11C, enc_r(0, 0, 6, 6'h20));
        load(32'h120, enc_r(1, 2, 7, 6'h22));
        load(32'h124, enc_r(1, 2, 8, 6'h24));
        load(32'h128, enc_r(1, 2, 9, 6'h25));
        load(32'h12C, enc_r(1, 2, 10, 6'h2A));
        for (int r = 0; r < 5; r++) load(32'h130 + 32'(4 * r), enc_i(6'h2B, 0, 6 + r, 32'h208 + 4 * r));
        expect_tx(0, 32'h100, 0, 1);
        expect_tx(0, 32'h104, 0, 4);
        expect_tx(0, 32'h108, 0, 4);
        expect_tx(0, 32'h10C, 0, 4);
        expect_tx(0, 32'h110, 0, 4);
        expect_tx(1, 32'h200, 32'd2, 3);
        expect_tx(0, 32'h114, 0, 1);
        expect_tx(1, 32'h204, 32'd1, 3);
        expect_tx(0, 32'h118, 0, 1);
        for (int k = 0; k < 6; k++) expect_tx(0, 32'h11C + 32'(4 * k), 0, 4);
        expect_tx(1, 32'h208, 32'h0000_0000, 3);
        expect_tx(0, 32'h134, 0, 1);
        expect_tx(1, 32'h20C, 32'h0000_0008, 3);
        expect_tx(0, 32'h138, 0, 1);
        expect_tx(1, 32'h210, 32'h0000_0005, 3);
        expect_tx(0, 32'h13C, 0, 1);
        expect_tx(1, 32'h214, 32'hFFFF_FFFD, 3);
        expect_tx(0, 32'h140, 0, 1);
        expect_tx(1, 32'h218, 32'h0000_0000, 3);
        expect_tx(0, 32'h144, 0, 1);
        run_to_halt(2'd1);
`ifdef MPS_PERF_COUNTERS_EN
        chk("instret", instret, 32'd17);
`endif

        // Store then load with two wait cycles per access
        begin_test("ldst_wait2", 2);
        load(32'h100, enc_i(6'h08, 0, 1, 32'h40));
        load(32'h104, enc_i(6'h2B, 1, 1, 4));
        load(32'h108, enc_i(6'h23, 1, 5, 4));
        load(32'h10C, enc_i(6'h2B, 0, 5, 32'h80));
        expect_tx(0, 32'h100, 0, 3);
        expect_tx(0, 32'h104, 0, 6);
        expect_tx(1, 32'h044, 32'h40, 5);
        expect_tx(0, 32'h108, 0, 3);
        expect_tx(0, 32'h044, 0, 5);
        expect_tx(0, 32'h10C, 0, 4);
        expect_tx(1, 32'h080, 32'h40, 5);
        expect_tx(0, 32'h110, 0, 3);
        run_to_halt(2'd1);

        // Jumps and branches
        begin_test("branch", 0);
        load(32'h100, enc_j(4));
        load(32'h010, enc_i(6'h04, 0, 0, 2));
        load(32'h01C, enc_j(32'h100));
        load(32'h400, enc_i(6'h08, 0, 1, 1));
        load(32'h404, enc_i(6'h04, 1, 0, 5));
        expect_tx(0, 32'h100, 0, 1);
        expect_tx(0, 32'h010, 0, 3);
        expect_tx(0, 32'h01C, 0, 3);
        expect_tx(0, 32'h400, 0, 3);
        expect_tx(0, 32'h404, 0, 4);
        expect_tx(0, 32'h408, 0, 3);
        run_to_halt(2'd1);

        // Misaligned load: fault with no data access
        begin_test("misaligned", 0);
        load(32'h100, enc_i(6'h08, 0, 1, 32'h41));
        load(32'h104, enc_i(6'h23, 1, 2, 0));
        expect_tx(0, 32'h100, 0, 1);
        expect_tx(0, 32'h104, 0, 4);
        run_to_halt(2'd3);

        // Ready never arrives: timeout fault, nothing accepted
        begin_test("timeout", 1000);
        run_to_halt(2'd2);

        // Ready on the timeout edge wins
        begin_test("wait_at_limit", 4);
        load(32'h100, enc_i(6'h08, 0, 1, 9));
        load(32'h104, enc_i(6'h2B, 0, 1, 32'h80));
        expect_tx(0, 32'h100, 0, 5);
        expect_tx(0, 32'h104, 0, 8);
        expect_tx(1, 32'h080, 32'd9, 7);
        expect_tx(0, 32'h108, 0, 5);
        run_to_halt(2'd1);

        // Reset during a data wait
        begin_test("reset_mid_mem", 2);
        load(32'h100, enc_i(6'h08, 0, 1, 32'h40));
        load(32'h104, enc_i(6'h23, 1, 5, 4));
        expect_tx(0, 32'h100, 0, 3);
        expect_tx(0, 32'h104, 0, 6);
        release_reset();
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clock);
            if (mem_req && !mem_we && (mem_addr == 32'h44)) found = 1'b1;
        end
        chk("reached_mem_wait", 32'(found), 32'd1);
        #2 nreset = 1'b0;
        #1;
        chk("req_dropped", 32'(mem_req), 32'd0);
        chk("pc_reset", pc, 32'h100);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // Registers are cleared by that reset
        begin_test("regs_cleared", 0);
        load(32'h100, enc_i(6'h2B, 0, 1, 32'h80));
        load(32'h104, enc_i(6'h2B, 0, 5, 32'h84));
        expect_tx(0, 32'h100, 0, 1);
        expect_tx(1, 32'h080, 32'h0, 3);
        expect_tx(0, 32'h104, 0, 1);
        expect_tx(1, 32'h084, 32'h0, 3);
        expect_tx(0, 32'h108, 0, 1);
        run_to_halt(2'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
